fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined ARM core: the reading end of the instruction-memory interface. It owns the program counter and drives a word-indexed, combinational-read instruction memory with byte addresses. It registers the returned instruction and PC+4 into the IF/ID pipeline register. It handles pipeline freeze (hazard unit) and branch redirect with flush (EXE stage).

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value after reset; must be word-aligned.
- IMEM_DEPTH, 51: number of 32-bit words in the instruction memory; fetches at or beyond this index are out of range.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- freeze  in  1  hazard stall; hold PC and IF/ID contents.
- branch_taken  in  1  redirect request from EXE; also flushes IF/ID.
- branch_addr  in  32  byte address of the branch target.
- imem_addr  out  32  byte address to the instruction memory; equals PC.
- imem_instr  in  32  instruction word returned combinationally for imem_addr.
- pc_out  out  32  IF/ID register: PC+4 of the latched instruction.
- instr_out  out  32  IF/ID register: latched instruction.
- valid_out  out  1  IF/ID register: instr_out is a real fetched instruction.
- addr_fault  out  1  sticky flag: an out-of-range fetch was latched.
- Present only with the perf-counter macro: fetch_cnt, stall_cnt and flush_cnt, each out, 32 bits, described under Configuration.

## Operation
- PC is 32 bits, and PC[1:0] is always 00. branch_addr[1:0] is ignored (forced to 00).
- The next-PC priority per edge is, from highest to lowest:
  - rst: PC <= RESET_PC.
  - branch_taken: PC <= {branch_addr[31:2], 2'b00}.
  - freeze: PC holds.
  - Otherwise: PC <= PC + 4, wrapping modulo 2^32.
- The IF/ID update priority per edge is, from highest to lowest:
  - rst or branch_taken: instr_out <= 0, pc_out <= 0, valid_out <= 0.
  - freeze: all IF/ID outputs hold.
  - Otherwise: instr_out <= imem_instr, pc_out <= PC + 4, valid_out <= 1. If PC[31:2] >= IMEM_DEPTH, instr_out <= 0 and valid_out <= 0 instead.
- branch_taken asserted together with freeze means the branch wins: PC redirects and IF/ID flushes.
- addr_fault is set on any edge where an out-of-range fetch would otherwise have been latched. It is cleared only by rst.
- The stage has no FSM beyond the PC/IF-ID registers. Behaviour is a pure function of PC, the inputs and the priority order above.

## Timing
- imem_addr is combinational from the PC register, so there is zero-cycle address-to-instruction latency at the memory.
- One-cycle latency from PC to the IF/ID outputs.
- Branch redirect: branch_taken sampled at edge N gives PC = target after edge N. The first target instruction appears on instr_out after edge N+1. The instruction in fetch at edge N is discarded, one bubble.
- Freeze is honoured on the same edge it is sampled. Releasing freeze resumes fetch from the held PC with no lost or duplicated instruction.
- Reset values: PC = RESET_PC, imem_addr = RESET_PC, pc_out = 0, instr_out = 0, valid_out = 0, addr_fault = 0, all counters = 0.
- rst mid-freeze or mid-branch: rst has priority and the next cycle fetches RESET_PC.

## Configuration
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds the fetch_cnt, stall_cnt and flush_cnt ports, each 32-bit and saturating at 32'hFFFF_FFFF.
  - fetch_cnt increments on each edge that latches valid_out = 1.
  - stall_cnt increments on edges with freeze = 1 and branch_taken = 0.
  - flush_cnt increments on edges with branch_taken = 1.
  - rst has priority over increments.
- Undefined: the ports and counter logic are absent. All other behaviour is identical.

## Structure
- Package arm_fetch_pkg holds:
  - INSTR_W = 32 and ADDR_W = 32.
  - The default reset PC constant.
  - The flush/bubble instruction constant BUBBLE_INSTR = 32'h0000_0000.
  - A packed struct if_id_t with fields pc, instr and valid.
- One sub-module, fetch_perf_counters, instantiated only under FETCH_PERF_CNT_EN. It holds the three saturating counters.

## Test plan
- Reset then 3 free-running cycles against a memory preloaded with words 0–2:
  - imem_addr steps 0 → 4 → 8.
  - instr_out presents words 0, 1, 2 on consecutive cycles.
  - pc_out presents 4, 8, 12.
  - valid_out = 1 throughout.
- Freeze for 2 cycles while PC = 8:
  - imem_addr stays 8.
  - IF/ID holds word 1 and pc_out = 8.
  - After release, word 2 is latched with no gap or duplicate.
- branch_taken with branch_addr = 32'h0000_0013 while PC = 20:
  - Next imem_addr = 16, and the next-cycle outputs are valid_out = 0, instr_out = 0.
  - Word 4 follows with pc_out = 20.
- branch_taken and freeze asserted together:
  - The redirect and the flush occur.
  - With FETCH_PERF_CNT_EN, flush_cnt increments and stall_cnt does not.
- Run PC to 200 (word 50), then 204 with the default IMEM_DEPTH = 51:
  - Word 50 is valid.
  - The next latch has valid_out = 0 and addr_fault = 1.
  - addr_fault stays 1 after a branch back to 0 and clears only on rst.
- Assert rst during a freeze at PC = 40:
  - Next cycle imem_addr = RESET_PC.
  - All IF/ID outputs and counters are 0.

Source files
------------

// File: rtl/arm_fetch_pkg.sv
// rtl/arm_fetch_pkg.sv - shared widths, constants and IF/ID register type for the fetch stage
package arm_fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] BUBBLE_INSTR     = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } if_id_t;
endpackage

// File: rtl/fetch_perf_counters.sv
// rtl/fetch_perf_counters.sv - saturating fetch/stall/flush event counters
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc_i,
  input  logic        stall_inc_i,
  input  logic        flush_inc_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);
  logic [31:0] fetch_q, stall_q, flush_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      fetch_q <= sat_inc(fetch_q, fetch_inc_i);
      stall_q <= sat_inc(stall_q, stall_inc_i);
      flush_q <= sat_inc(flush_q, flush_inc_i);
    end
  end

  assign fetch_cnt_o = fetch_q;
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, IF/ID register, freeze and branch flush; FETCH_PERF_CNT_EN adds event counters
module fetch_stage
  import arm_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int                IMEM_DEPTH = 51
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic               valid_out,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt,
`endif
  output logic               addr_fault
);
  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(IMEM_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4;
  if_id_t            ifid_q, ifid_d;
  logic              fault_q, fault_d;
  logic              in_range, advance;

  assign pc_plus4 = pc_q + 32'd4;
  assign in_range = {2'b00, pc_q[ADDR_W-1:2]} < DEPTH_W;
  assign advance  = !branch_taken && !freeze;

  always_comb begin
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    fault_d = fault_q;
    if (branch_taken) begin
      pc_d   = {branch_addr[ADDR_W-1:2], 2'b00};
      ifid_d = '{pc: '0, instr: BUBBLE_INSTR, valid: 1'b0};
    end else if (!freeze) begin
      pc_d      = pc_plus4;
      ifid_d.pc = pc_plus4;
      if (in_range) begin
        ifid_d.instr = imem_instr;
        ifid_d.valid = 1'b1;
      end else begin
        // Out-of-range words are never forwarded as real instructions.
        ifid_d.instr = BUBBLE_INSTR;
        ifid_d.valid = 1'b0;
        fault_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      ifid_q  <= '{pc: '0, instr: BUBBLE_INSTR, valid: 1'b0};
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      fault_q <= fault_d;
    end
  end

  assign imem_addr  = pc_q;
  assign pc_out     = ifid_q.pc;
  assign instr_out  = ifid_q.instr;
  assign valid_out  = ifid_q.valid;
  assign addr_fault = fault_q;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counters u_perf (
    .clk         (clk),
    .rst         (rst),
    .fetch_inc_i (advance && in_range),
    .stall_inc_i (freeze && !branch_taken),
    .flush_inc_i (branch_taken),
    .fetch_cnt_o (fetch_cnt),
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
  );
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage against a behavioural fetch model
module tb_fetch_stage;
  localparam int DEPTH = 51;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken;
  logic [31:0] branch_addr, imem_addr, imem_instr, pc_out, instr_out;
  logic        valid_out, addr_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0), .IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .pc_out(pc_out), .instr_out(instr_out), .valid_out(valid_out),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .addr_fault(addr_fault)
  );

  // Memory is larger than IMEM_DEPTH so out-of-range reads return non-zero data.
  logic [31:0] mem [0:63];
  assign imem_instr = (imem_addr[31:2] < 30'd64) ? mem[imem_addr[7:2]] : 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] addr, pc, instr;
    logic        valid, fault;
    logic [31:0] nf, ns, nl;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;

  longint      m_pc;
  logic [31:0] m_pco, m_ins;
  logic        m_val, m_fault;
  longint      m_nf, m_ns, m_nl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle and push the model's view of the state after the edge.
  task automatic step(input logic r, input logic f, input logic b, input logic [31:0] a);
    exp_t e;
    @(negedge clk);
    rst = r; freeze = f; branch_taken = b; branch_addr = a;
    if (r) begin
      m_pc = 0; m_pco = 0; m_ins = 0; m_val = 0; m_fault = 0;
      m_nf = 0; m_ns = 0; m_nl = 0;
    end else if (b) begin
      m_pc = a & 32'hFFFF_FFFC; m_pco = 0; m_ins = 0; m_val = 0;
      m_nl++;
    end else if (f) begin
      m_ns++;
    end else begin
      m_pco = 32'((m_pc + 4) % 64'h1_0000_0000);
      if (m_pc / 4 < DEPTH) begin
        m_ins = mem[m_pc / 4]; m_val = 1; m_nf++;
      end else begin
        m_ins = 0; m_val = 0; m_fault = 1;
      end
      m_pc = (m_pc + 4) % 64'h1_0000_0000;
    end
    e.addr = 32'(m_pc); e.pc = m_pco; e.instr = m_ins; e.valid = m_val; e.fault = m_fault;
    e.nf = 32'(m_nf); e.ns = 32'(m_ns); e.nl = 32'(m_nl);
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("imem_addr", imem_addr, e.addr);
      chk("pc_out", pc_out, e.pc);
      chk("instr_out", instr_out, e.instr);
      chk("valid_out", {31'd0, valid_out}, {31'd0, e.valid});
      chk("addr_fault", {31'd0, addr_fault}, {31'd0, e.fault});
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_cnt", fetch_cnt, e.nf);
      chk("stall_cnt", stall_cnt, e.ns);
      chk("flush_cnt", flush_cnt, e.nl);
`endif
    end
  end

  initial begin
    rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom | 32'h1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0013);
    repeat (2) step(0, 0, 0, 0);
    step(0, 1, 1, 32'h0000_0040);
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 1, 32'd196);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 1, 32'd0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 1, 32'd40);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 1, 32'hFFFF_FFFC);
    repeat (3) step(0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      logic r, f, b;
      logic [31:0] a;
      r = ($urandom_range(0, 99) < 2);
      f = ($urandom_range(0, 99) < 20);
      b = ($urandom_range(0, 99) < 10);
      a = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 260);
      step(r, f, b, a);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
